// File: rtl/play_ctrl_pkg.sv
// play_pkg: shared definitions for the playback sequencer.
//   - state_e     : sequencer state encoding (also driven on STATE)
//   - NOTE_REST   : note index that means "silence"
//   - song_start / song_end : song table for the shared note ROM
//       song0 0..138, song1 139..179, song2 180..219, song3 220..255
package play_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  localparam int unsigned NOTE_W    = 4;
  localparam logic [3:0]  NOTE_REST = 4'd0;

  // First ROM address of each song.
  function automatic logic [7:0] song_start(input logic [1:0] id);
    case (id)
      2'd0:    song_start = 8'd0;
      2'd1:    song_start = 8'd139;
      2'd2:    song_start = 8'd180;
      default: song_start = 8'd220;
    endcase
  endfunction

  // Last ROM address of each song; this note is still played.
  function automatic logic [7:0] song_end(input logic [1:0] id);
    case (id)
      2'd0:    song_end = 8'd138;
      2'd1:    song_end = 8'd179;
      2'd2:    song_end = 8'd219;
      default: song_end = 8'd255;
    endcase
  endfunction

endpackage

// File: rtl/play_ctrl_if.sv
// play_ctrl_if: key, ROM and status signals of the playback sequencer.
//   play_key/stop_key/next_key : single-cycle key pulses into the sequencer
//   rom_q    : note index from the synchronous note ROM (1-cycle latency)
//   rom_addr : ROM address from the sequencer
//   inx      : registered note index to the frequency-code block
//   mute     : 1 = silence speaker
//   song_id  : current song
//   state    : 00 IDLE, 01 PLAY, 10 PAUSE
// Modports: master = key source / ROM side, slave = play_ctrl.
interface play_ctrl_if
  import play_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned SONG_W = 2
);

  logic              play_key;
  logic              stop_key;
  logic              next_key;
  logic [NOTE_W-1:0] rom_q;
  logic [ADDR_W-1:0] rom_addr;
  logic [NOTE_W-1:0] inx;
  logic              mute;
  logic [SONG_W-1:0] song_id;
  logic [1:0]        state;

  modport master (
    output play_key, stop_key, next_key, rom_q,
    input  rom_addr, inx, mute, song_id, state
  );

  modport slave (
    input  play_key, stop_key, next_key, rom_q,
    output rom_addr, inx, mute, song_id, state
  );

endinterface

// File: rtl/play_ctrl_beat_gen.sv
// beat_gen: beat prescaler. Counts 0..DIV-1 while enabled, holds its value
// while disabled, and clears when clr_i is high (clear wins over enable).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : count enable
//   clr_i      : synchronous clear
//   tick_o     : high for one cycle while the count sits at DIV-1 and is enabled
module beat_gen #(
  parameter int unsigned DIV = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned   CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/play_ctrl.sv
// play_ctrl: PLAY/PAUSE/STOP/NEXT playback sequencer for the note ROM.
// Ports:
//   clk   : system clock (CLK_HZ)
//   rst_n : asynchronous active-low reset
//   bus   : play_ctrl_if.slave (keys, ROM address/data, INX, MUTE, SONG_ID, STATE)
// Build option: define AUTO_LOOP_EN to restart the current song at its end
// instead of returning to IDLE.
module play_ctrl
  import play_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 1000000,
  parameter int unsigned BEAT_HZ   = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned NUM_SONGS = 4,
  parameter int unsigned GAP_CYC   = 20000
) (
  input logic        clk,
  input logic        rst_n,
  play_ctrl_if.slave bus
);

  localparam int unsigned SONG_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
  localparam int unsigned GAP_W  = $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);

  state_e            state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d, next_song;
  logic [ADDR_W-1:0] addr_q, addr_d, start_addr;
  logic [NOTE_W-1:0] inx_q, inx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              presc_clr;
  logic              beat_tick;

  beat_gen #(
    .DIV (CLK_HZ / BEAT_HZ)
  ) u_beat_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == ST_PLAY),
    .clr_i  (presc_clr),
    .tick_o (beat_tick)
  );

  // Keys are decoded STOP > NEXT > PLAY and any key masks the beat tick.
  // In PLAY, INX reloads from ROM_Q every cycle: ROM_Q reflects the address
  // of the previous cycle, so a new address reaches INX two edges later.
  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    addr_d     = addr_q;
    inx_d      = inx_q;
    gap_d      = gap_q;
    presc_clr  = 1'b0;
    start_addr = ADDR_W'(song_start(song_q));
    next_song  = song_q + 1'b1;

    unique case (state_q)
      ST_PLAY: begin
        inx_d = bus.rom_q;
        if (gap_q != '0) gap_d = gap_q - 1'b1;
      end
      ST_IDLE: begin
        inx_d     = NOTE_REST;
        presc_clr = 1'b1;
      end
      default: ;
    endcase

    if (bus.stop_key) begin
      state_d   = ST_IDLE;
      addr_d    = start_addr;
      inx_d     = NOTE_REST;
      gap_d     = '0;
      presc_clr = 1'b1;
    end else if (bus.next_key) begin
      song_d    = next_song;
      addr_d    = ADDR_W'(song_start(next_song));
      presc_clr = 1'b1;
      if (state_q == ST_PLAY) begin
        gap_d = GAP_LOAD;
      end else if (state_q == ST_PAUSE) begin
        state_d = ST_IDLE;
        inx_d   = NOTE_REST;
        gap_d   = '0;
      end
    end else if (bus.play_key) begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_PLAY;
          gap_d   = GAP_LOAD;
        end
        ST_PLAY: begin
          state_d = ST_PAUSE;
          inx_d   = inx_q;
        end
        default: state_d = ST_PLAY;
      endcase
    end else if (beat_tick) begin
      if (addr_q != ADDR_W'(song_end(song_q))) begin
        addr_d = addr_q + 1'b1;
        gap_d  = GAP_LOAD;
      end else begin
`ifdef AUTO_LOOP_EN
        addr_d = start_addr;
        gap_d  = GAP_LOAD;
`else
        state_d = ST_IDLE;
        addr_d  = start_addr;
        inx_d   = NOTE_REST;
        gap_d   = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      song_q  <= '0;
      addr_q  <= ADDR_W'(song_start(2'd0));
      inx_q   <= NOTE_REST;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      addr_q  <= addr_d;
      inx_q   <= inx_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.rom_addr = addr_q;
  assign bus.inx      = inx_q;
  assign bus.song_id  = song_q;
  assign bus.state    = state_q;
  assign bus.mute     = (state_q != ST_PLAY) || (gap_q != '0);

endmodule

// File: tb/tb_play_ctrl.sv
// tb_play_ctrl: directed bench for play_ctrl with a 10-cycle beat
// (CLK_HZ=40, BEAT_HZ=4) and a 2-cycle gap. The ROM model returns the low
// nibble of the address one cycle after it is presented.
module tb_play_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checkCount = 0;
  int   passCount  = 0;

  play_ctrl_if #(.ADDR_W(8), .SONG_W(2)) pif ();

  play_ctrl #(
    .CLK_HZ    (40),
    .BEAT_HZ   (4),
    .ADDR_W    (8),
    .NUM_SONGS (4),
    .GAP_CYC   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pif)
  );

  always #5 clk = ~clk;

  // Synchronous note ROM: Q = address[3:0], one cycle of latency.
  always @(posedge clk) pif.rom_q <= pif.rom_addr[3:0];

  // Drive a one-cycle key pulse from a negedge; returns at the next negedge.
  task automatic press(input logic p, input logic s, input logic n);
    pif.play_key = p;
    pif.stop_key = s;
    pif.next_key = n;
    @(negedge clk);
    pif.play_key = 1'b0;
    pif.stop_key = 1'b0;
    pif.next_key = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checkCount++;
    if (pif.state !== 2'b00) $display("[TB] FAIL reset_state: got %b expected 00", pif.state);
    else passCount++;
    checkCount++;
    if (pif.rom_addr !== 8'd0) $display("[TB] FAIL reset_addr: got %0d expected 0", pif.rom_addr);
    else passCount++;
    checkCount++;
    if (pif.inx !== 4'd0) $display("[TB] FAIL reset_inx: got %0d expected 0", pif.inx);
    else passCount++;
    checkCount++;
    if (pif.mute !== 1'b1) $display("[TB] FAIL reset_mute: got %b expected 1", pif.mute);
    else passCount++;
    checkCount++;
    if (pif.song_id !== 2'd0) $display("[TB] FAIL reset_song: got %0d expected 0", pif.song_id);
    else passCount++;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
  endtask

  task automatic test_play;
    press(1'b1, 1'b0, 1'b0);
    checkCount++;
    if (pif.state !== 2'b01 || pif.mute !== 1'b1)
      $display("[TB] FAIL play_entry: got state %b mute %b expected 01/1", pif.state, pif.mute);
    else passCount++;
    cycles(2);
    checkCount++;
    if (pif.mute !== 1'b0) $display("[TB] FAIL play_gap_end: got mute %b expected 0", pif.mute);
    else passCount++;
    cycles(7);
    checkCount++;
    if (pif.rom_addr !== 8'd0) $display("[TB] FAIL play_before_tick: got %0d expected 0", pif.rom_addr);
    else passCount++;
    cycles(1);
    checkCount++;
    if (pif.rom_addr !== 8'd1 || pif.mute !== 1'b1)
      $display("[TB] FAIL play_step1: got addr %0d mute %b expected 1/1", pif.rom_addr, pif.mute);
    else passCount++;
    cycles(1);
    checkCount++;
    if (pif.inx !== 4'd0) $display("[TB] FAIL play_inx_latency: got %0d expected 0", pif.inx);
    else passCount++;
    cycles(1);
    checkCount++;
    if (pif.inx !== 4'd1 || pif.mute !== 1'b0)
      $display("[TB] FAIL play_inx1: got inx %0d mute %b expected 1/0", pif.inx, pif.mute);
    else passCount++;
    cycles(8);
    checkCount++;
    if (pif.rom_addr !== 8'd2) $display("[TB] FAIL play_step2: got %0d expected 2", pif.rom_addr);
    else passCount++;
    cycles(2);
    checkCount++;
    if (pif.inx !== 4'd2) $display("[TB] FAIL play_inx2: got %0d expected 2", pif.inx);
    else passCount++;
  endtask

  task automatic test_end_of_song;
    int n;
    n = 0;
    while (pif.rom_addr !== 8'd138 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkCount++;
    if (n >= 2000) $display("[TB] FAIL eos_reach: got addr %0d expected 138 within 2000 cycles", pif.rom_addr);
    else passCount++;
    cycles(9);
    checkCount++;
    if (pif.rom_addr !== 8'd138 || pif.state !== 2'b01)
      $display("[TB] FAIL eos_last_note: got addr %0d state %b expected 138/01", pif.rom_addr, pif.state);
    else passCount++;
    cycles(1);
`ifdef AUTO_LOOP_EN
    checkCount++;
    if (pif.rom_addr !== 8'd0 || pif.state !== 2'b01 || pif.mute !== 1'b1)
      $display("[TB] FAIL eos_loop: got addr %0d state %b mute %b expected 0/01/1",
               pif.rom_addr, pif.state, pif.mute);
    else passCount++;
`else
    checkCount++;
    if (pif.rom_addr !== 8'd0 || pif.state !== 2'b00 || pif.mute !== 1'b1 || pif.inx !== 4'd0)
      $display("[TB] FAIL eos_stop: got addr %0d state %b mute %b inx %0d expected 0/00/1/0",
               pif.rom_addr, pif.state, pif.mute, pif.inx);
    else passCount++;
`endif
    press(1'b0, 1'b1, 1'b0);
    checkCount++;
    if (pif.state !== 2'b00) $display("[TB] FAIL eos_idle: got %b expected 00", pif.state);
    else passCount++;
  endtask

  task automatic test_pause;
    press(1'b1, 1'b0, 1'b0);
    cycles(50);
    checkCount++;
    if (pif.rom_addr !== 8'd5) $display("[TB] FAIL pause_addr5: got %0d expected 5", pif.rom_addr);
    else passCount++;
    cycles(6);
    press(1'b1, 1'b0, 1'b0);
    checkCount++;
    if (pif.state !== 2'b10 || pif.mute !== 1'b1)
      $display("[TB] FAIL pause_enter: got state %b mute %b expected 10/1", pif.state, pif.mute);
    else passCount++;
    cycles(50);
    checkCount++;
    if (pif.state !== 2'b10 || pif.rom_addr !== 8'd5 || pif.inx !== 4'd5 || pif.mute !== 1'b1)
      $display("[TB] FAIL pause_hold: got state %b addr %0d inx %0d mute %b expected 10/5/5/1",
               pif.state, pif.rom_addr, pif.inx, pif.mute);
    else passCount++;
    press(1'b1, 1'b0, 1'b0);
    checkCount++;
    if (pif.state !== 2'b01 || pif.mute !== 1'b0 || pif.rom_addr !== 8'd5)
      $display("[TB] FAIL pause_resume: got state %b mute %b addr %0d expected 01/0/5",
               pif.state, pif.mute, pif.rom_addr);
    else passCount++;
    cycles(2);
    checkCount++;
    if (pif.rom_addr !== 8'd5) $display("[TB] FAIL resume_early: got %0d expected 5", pif.rom_addr);
    else passCount++;
    cycles(1);
    checkCount++;
    if (pif.rom_addr !== 8'd6) $display("[TB] FAIL resume_step: got %0d expected 6", pif.rom_addr);
    else passCount++;
    press(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_key_priority;
    press(1'b1, 1'b0, 1'b0);
    cycles(200);
    checkCount++;
    if (pif.rom_addr !== 8'd20) $display("[TB] FAIL prio_addr20: got %0d expected 20", pif.rom_addr);
    else passCount++;
    press(1'b1, 1'b1, 1'b1);
    checkCount++;
    if (pif.state !== 2'b00 || pif.song_id !== 2'd0 || pif.rom_addr !== 8'd0 ||
        pif.inx !== 4'd0 || pif.mute !== 1'b1)
      $display("[TB] FAIL prio_stop: got state %b song %0d addr %0d inx %0d mute %b expected 00/0/0/0/1",
               pif.state, pif.song_id, pif.rom_addr, pif.inx, pif.mute);
    else passCount++;
    press(1'b0, 1'b0, 1'b1);
    checkCount++;
    if (pif.song_id !== 2'd1 || pif.rom_addr !== 8'd139 || pif.state !== 2'b00)
      $display("[TB] FAIL next_idle: got song %0d addr %0d state %b expected 1/139/00",
               pif.song_id, pif.rom_addr, pif.state);
    else passCount++;
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    checkCount++;
    if (pif.song_id !== 2'd3 || pif.rom_addr !== 8'd220)
      $display("[TB] FAIL next_song3: got song %0d addr %0d expected 3/220", pif.song_id, pif.rom_addr);
    else passCount++;
    press(1'b1, 1'b0, 1'b0);
    cycles(5);
    press(1'b0, 1'b0, 1'b1);
    checkCount++;
    if (pif.song_id !== 2'd0 || pif.rom_addr !== 8'd0 || pif.state !== 2'b01 || pif.mute !== 1'b1)
      $display("[TB] FAIL next_wrap: got song %0d addr %0d state %b mute %b expected 0/0/01/1",
               pif.song_id, pif.rom_addr, pif.state, pif.mute);
    else passCount++;
    cycles(9);
    checkCount++;
    if (pif.rom_addr !== 8'd0) $display("[TB] FAIL next_presc_clr: got %0d expected 0", pif.rom_addr);
    else passCount++;
    cycles(1);
    checkCount++;
    if (pif.rom_addr !== 8'd1) $display("[TB] FAIL next_step: got %0d expected 1", pif.rom_addr);
    else passCount++;
  endtask

  task automatic test_async_reset;
    press(1'b0, 1'b0, 1'b1);
    cycles(25);
    checkCount++;
    if (pif.song_id !== 2'd1 || pif.rom_addr !== 8'd141 || pif.state !== 2'b01)
      $display("[TB] FAIL arst_pre: got song %0d addr %0d state %b expected 1/141/01",
               pif.song_id, pif.rom_addr, pif.state);
    else passCount++;
    #2 rst_n = 1'b0;
    #1;
    checkCount++;
    if (pif.state !== 2'b00 || pif.rom_addr !== 8'd0 || pif.mute !== 1'b1 ||
        pif.song_id !== 2'd0 || pif.inx !== 4'd0)
      $display("[TB] FAIL arst_async: got state %b addr %0d mute %b song %0d inx %0d expected 00/0/1/0/0",
               pif.state, pif.rom_addr, pif.mute, pif.song_id, pif.inx);
    else passCount++;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    press(1'b1, 1'b0, 1'b0);
    checkCount++;
    if (pif.state !== 2'b01 || pif.rom_addr !== 8'd0 || pif.song_id !== 2'd0)
      $display("[TB] FAIL arst_restart: got state %b addr %0d song %0d expected 01/0/0",
               pif.state, pif.rom_addr, pif.song_id);
    else passCount++;
    cycles(10);
    checkCount++;
    if (pif.rom_addr !== 8'd1) $display("[TB] FAIL arst_step: got %0d expected 1", pif.rom_addr);
    else passCount++;
  endtask

  initial begin
    pif.play_key = 1'b0;
    pif.stop_key = 1'b0;
    pif.next_key = 1'b0;
    test_reset();
    test_play();
    test_end_of_song();
    test_pause();
    test_key_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/play_ctrl.md
Name: play_ctrl

Overview:
Playback sequencer for the music player. It replaces the free-running note address counter with a PLAY/PAUSE/STOP/NEXT controlled sequencer for the note ROM. It runs on the 1 MHz clock, generates the beat tick internally, selects among several songs stored in one ROM, and registers the note index for the frequency-code block. It drives MUTE to gate the speaker during idle, pause and the inter-note articulation gap.

Parameters:
CLK_HZ, 1000000, input clock frequency
BEAT_HZ, 4, notes per second
ADDR_W, 8, ROM address width
NUM_SONGS, 4, songs in ROM (power of two)
GAP_CYC, 20000, cycles MUTE is held high after each beat tick (20 ms)

Ports:
CLK  in  1  1 MHz system clock
RST  in  1  asynchronous, active-low reset
PLAY_KEY  in  1  single-cycle pulse (debounced upstream); play/pause toggle
STOP_KEY  in  1  single-cycle pulse; stop, rewind current song
NEXT_KEY  in  1  single-cycle pulse; select next song
ROM_Q  in  4  note index from synchronous ROM, 1-cycle read latency
ROM_ADDR  out  ADDR_W  registered ROM address
INX  out  4  registered note index to frequency-code block
MUTE  out  1  1 = silence speaker
SONG_ID  out  log2(NUM_SONGS)  current song
STATE  out  2  00 IDLE, 01 PLAY, 10 PAUSE

Behaviour:
- Single clock CLK. RST is asynchronous and active-low.
- Reset values: STATE=IDLE, SONG_ID=0, ROM_ADDR=SONG_START[0], INX=0, MUTE=1, prescaler=0, gap counter=0.
- Prescaler: counts 0..CLK_HZ/BEAT_HZ-1 and pulses beat_tick when at max, then wraps to 0.
  - Counts only in PLAY. Frozen in PAUSE. Cleared in IDLE and on any song change or restart.
- Fetch latency: INX loads ROM_Q exactly 2 cycles after ROM_ADDR changes. This covers the ROM registering the address plus the INX register. INX is also reloaded on entry to PLAY from IDLE.
- Key priority in one cycle: STOP > NEXT > PLAY. A key in the same cycle as beat_tick wins and the tick is discarded.
- IDLE:
  - MUTE=1; ROM_ADDR=SONG_START[SONG_ID].
  - PLAY_KEY -> PLAY with prescaler=0 and gap counter loaded with GAP_CYC.
- PLAY:
  - On beat_tick with ROM_ADDR != SONG_END[SONG_ID]: ROM_ADDR+1 and gap counter loaded with GAP_CYC.
  - On beat_tick with ROM_ADDR == SONG_END[SONG_ID] (end address inclusive): end-of-song handling, see Optional Feature.
  - PLAY_KEY -> PAUSE.
- PAUSE:
  - MUTE=1; ROM_ADDR, INX, prescaler and gap counter held.
  - PLAY_KEY -> PLAY; prescaler resumes from its frozen value; gap counter is not reloaded.
- STOP_KEY (any state): -> IDLE; ROM_ADDR=SONG_START[SONG_ID]; prescaler cleared; INX=0.
- NEXT_KEY: SONG_ID=(SONG_ID+1) mod NUM_SONGS; ROM_ADDR=new start; prescaler cleared.
  - IDLE stays IDLE.
  - PLAY stays PLAY from the new song's start, with gap reloaded.
  - PAUSE -> IDLE.
- MUTE = (STATE != PLAY) or (gap counter != 0). The gap counter decrements to 0 only in PLAY.
- INX=0 is the rest code; the controller passes it through unchanged.
- Reset asserted mid-operation returns all outputs to reset values immediately, without waiting for a clock edge.

Optional Feature:
AUTO_LOOP_EN.
- Defined: at the end-of-song tick, ROM_ADDR wraps to SONG_START[SONG_ID], STATE stays PLAY and the gap counter is reloaded.
- Undefined: at the end-of-song tick, STATE -> IDLE, ROM_ADDR=SONG_START[SONG_ID], MUTE=1 and INX=0.

Decomposition:
- Package play_pkg holds:
  - STATE encoding constants (IDLE=2'b00, PLAY=2'b01, PAUSE=2'b10);
  - NOTE_REST=4'd0;
  - song table constants SONG_START/SONG_END: song0 0..138, song1 139..179, song2 180..219, song3 220..255.
- One sub-module, beat_gen: prescaler with enable/clear inputs and a beat_tick output.

Test Plan:
Bench setup: CLK_HZ=40, BEAT_HZ=4 (10 cycles/beat), GAP_CYC=2; ROM model returns Q=address[3:0].
1. Reset: RST low with no clock edges -> STATE=00, ROM_ADDR=0, INX=0, MUTE=1, SONG_ID=0.
2. PLAY pulse from IDLE -> STATE=01; ROM_ADDR steps 0,1,2 every 10 cycles; INX follows 2 cycles after each step; MUTE=1 for the 2 cycles after each tick, else 0.
3. Play through song0 -> at the tick with ROM_ADDR=138:
   - macro undefined: STATE=00, ROM_ADDR=0, MUTE=1;
   - AUTO_LOOP_EN defined: ROM_ADDR=0, STATE stays 01.
4. PLAY pulse at ROM_ADDR=5 with prescaler=6 -> STATE=10, MUTE=1 and all state held for 50 cycles. PLAY pulse again -> ROM_ADDR=6 after 3 active cycles, not 10.
5. STOP+NEXT+PLAY in the same cycle during PLAY at ROM_ADDR=20 -> STATE=00, SONG_ID unchanged, ROM_ADDR=0. Separately, NEXT_KEY with SONG_ID=3 in PLAY -> SONG_ID=0, ROM_ADDR=0, STATE=01.
6. RST driven low between edges during PLAY -> ROM_ADDR=0, MUTE=1 and STATE=00 before the next CLK edge; after release, the first PLAY pulse restarts song0 cleanly.
